// File: rtl/uart_mult_link_if.sv
// Signal bundle between the UART byte pair, the multiplier core and the
// link engine. The engine takes the master modport.
interface uart_mult_link_if #(
  parameter int OPERAND_BYTES = 2
);
  localparam int W = 8 * OPERAND_BYTES;

  // Handshakes: rx_valid, tx_start, mult_start and mult_done are single-cycle
  // strobes sampled on the rising clock edge. There is no ready on the
  // receive side. tx_ready is a level: a byte is offered only while it is
  // high, and the transmitter acknowledges by dropping it, then raising it
  // again when the byte is done.
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           tx_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic           mult_start;
  logic           mult_done;
  logic [2*W-1:0] mult_result;
  logic           busy;
  logic           frame_error;
  logic           rx_overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready, mult_done, mult_result,
    output tx_data, tx_start, mult_a, mult_b, mult_start, busy,
           frame_error, rx_overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mult_done, mult_result,
    input  tx_data, tx_start, mult_a, mult_b, mult_start, busy,
           frame_error, rx_overrun
  );
endinterface

// File: rtl/uart_mult_link.sv
// Host-link engine: gathers two MSB-first operands from the UART byte stream,
// runs one multiply and returns the product MSB byte first.
module uart_mult_link #(
  parameter int          OPERAND_BYTES  = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                 clk_int,
  input  logic                 uart_reset,
  uart_mult_link_if.master     bus,
  output logic [2:0]           dbg_state
);
  localparam int W  = 8 * OPERAND_BYTES;
  localparam int NB = 2 * OPERAND_BYTES;
  localparam int CW = $clog2(NB + 1);
  localparam int IW = $clog2(NB);
  localparam logic [CW-1:0] OP_CNT   = CW'(OPERAND_BYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [23:0]   TMO_LAST = TIMEOUT_CYCLES - 24'd1;

  typedef enum logic [2:0] {
    S_RX         = 3'd0,
    S_START      = 3'd1,
    S_WAIT_MULT  = 3'd2,
    S_TX_SEND    = 3'd3,
    S_TX_WAIT_LO = 3'd4,
    S_TX_WAIT_HI = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q;
  logic [IW-1:0]  idx_q;
  logic [23:0]    tcnt_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] res_q;
  logic [7:0]     tx_data_q;
  logic           take_byte, timeout_hit, start_c, fire, overrun_c;

  always_ff @(posedge clk_int) begin
    if (uart_reset) state_q <= S_RX;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    take_byte   = 1'b0;
    timeout_hit = 1'b0;
    start_c     = 1'b0;
    fire        = 1'b0;
    case (state_q)
      S_RX: begin
        // A byte arriving on the terminal timeout cycle beats the timeout.
        if (bus.rx_valid) begin
          take_byte = 1'b1;
          if (count_q == LAST_CNT) state_d = S_START;
        end else if (count_q != '0 && tcnt_q == TMO_LAST) begin
          timeout_hit = 1'b1;
        end
      end
      S_START: begin
        start_c = 1'b1;
        state_d = S_WAIT_MULT;
      end
      S_WAIT_MULT:  if (bus.mult_done) state_d = S_TX_SEND;
      S_TX_SEND: begin
        if (bus.tx_ready) begin
          fire    = 1'b1;
          state_d = S_TX_WAIT_LO;
        end
      end
      S_TX_WAIT_LO: if (!bus.tx_ready) state_d = S_TX_WAIT_HI;
      S_TX_WAIT_HI: begin
        if (bus.tx_ready) state_d = (idx_q == LAST_IDX) ? S_RX : S_TX_SEND;
      end
      default: state_d = S_RX;
    endcase
    overrun_c = bus.rx_valid && (state_q != S_RX);
  end

  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      count_q   <= '0;
      idx_q     <= '0;
      tcnt_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      tx_data_q <= '0;
    end else begin
      if (take_byte) begin
        if (count_q < OP_CNT) a_q <= (a_q << 8) | W'(bus.rx_data);
        else                  b_q <= (b_q << 8) | W'(bus.rx_data);
        count_q <= count_q + 1'b1;
        tcnt_q  <= '0;
      end else if (timeout_hit) begin
        count_q <= '0;
        tcnt_q  <= '0;
        a_q     <= '0;
        b_q     <= '0;
      end else if (state_q == S_RX && count_q != '0) begin
        tcnt_q <= tcnt_q + 24'd1;
      end

      if (state_q == S_WAIT_MULT && bus.mult_done) begin
        res_q <= bus.mult_result;
        idx_q <= '0;
      end

      if (fire) tx_data_q <= res_q[2*W-1 -: 8];

      // The product is shifted up so the byte on offer is always the top one.
      if (state_q == S_TX_WAIT_HI && bus.tx_ready) begin
        if (idx_q == LAST_IDX) begin
          count_q <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
          res_q <= res_q << 8;
        end
      end
    end
  end

  assign bus.tx_start    = fire;
  assign bus.tx_data     = fire ? res_q[2*W-1 -: 8] : tx_data_q;
  assign bus.mult_a      = a_q;
  assign bus.mult_b      = b_q;
  assign bus.mult_start  = start_c;
  assign bus.busy        = !(state_q == S_RX && count_q == '0);
  assign bus.frame_error = timeout_hit;
  assign bus.rx_overrun  = overrun_c;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_uart_mult_link.sv
// Directed bench for uart_mult_link: scoreboard of expected operands and
// transmit bytes, with simple multiplier and transmitter models.
module tb_uart_mult_link;
  logic       clk_int;
  logic       uart_reset;
  logic [2:0] dbg_state;
  logic       tx_ready_m;
  logic       bp_hold;
  int         mult_lat;

  uart_mult_link_if #(.OPERAND_BYTES(2)) bus ();

  uart_mult_link #(
    .OPERAND_BYTES (2),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk_int   (clk_int),
    .uart_reset(uart_reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  assign bus.tx_ready = tx_ready_m & ~bp_hold;

  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_op_q[$];
  logic [31:0] prod_q[$];

  int vec, miss;
  int ms_cnt, tx_seen, fe_cnt, ov_cnt;

  // ---------------- clock / reset ----------------
  initial begin
    clk_int = 1'b0;
    forever #5 clk_int = ~clk_int;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_int);
    #1 bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(posedge clk_int);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic queue_frame(input logic [31:0] ops, input logic [31:0] prod);
    exp_op_q.push_back(ops);
    prod_q.push_back(prod);
    exp_tx_q.push_back(prod[31:24]);
    exp_tx_q.push_back(prod[23:16]);
    exp_tx_q.push_back(prod[15:8]);
    exp_tx_q.push_back(prod[7:0]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk_int);
    while (bus.busy && n < 3000) begin
      @(negedge clk_int);
      n++;
    end
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic finish_frame(input string name, input int ms0);
    wait_idle(name);
    check({name, "_mstart_cnt"}, ms_cnt - ms0, 32'd1);
    check({name, "_tx_left"}, exp_tx_q.size(), 32'd0);
    check({name, "_op_left"}, exp_op_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({name, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({name, "_mult_a"}, 32'(bus.mult_a), 32'd0);
    check({name, "_mult_b"}, 32'(bus.mult_b), 32'd0);
    check({name, "_mult_start"}, 32'(bus.mult_start), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_frame_error"}, 32'(bus.frame_error), 32'd0);
    check({name, "_rx_overrun"}, 32'(bus.rx_overrun), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- multiplier model ----------------
  initial begin
    logic [31:0] p;
    bus.mult_done   = 1'b0;
    bus.mult_result = '0;
    forever begin
      @(negedge clk_int);
      if (bus.mult_start) begin
        p = (prod_q.size() != 0) ? prod_q.pop_front() : 32'd0;
        repeat (mult_lat) @(posedge clk_int);
        #1 bus.mult_done = 1'b1;
        bus.mult_result = p;
        @(posedge clk_int);
        #1 bus.mult_done = 1'b0;
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin
    tx_ready_m = 1'b1;
    forever begin
      @(negedge clk_int);
      if (bus.tx_start) begin
        @(posedge clk_int);
        #1 tx_ready_m = 1'b0;
        repeat (3) @(posedge clk_int);
        #1 tx_ready_m = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic        prev_rxv;
    logic [31:0] e_op;
    logic [7:0]  e_tx;
    prev_rxv = 1'b0;
    forever begin
      @(negedge clk_int);
      if (bus.mult_start) begin
        ms_cnt++;
        check("mstart_expected", 32'(exp_op_q.size() != 0), 32'd1);
        if (exp_op_q.size() != 0) begin
          e_op = exp_op_q.pop_front();
          check("operands", {bus.mult_a, bus.mult_b}, e_op);
          check("mstart_latency", 32'(prev_rxv), 32'd1);
        end
      end
      if (bus.tx_start) begin
        tx_seen++;
        check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
        if (exp_tx_q.size() != 0) begin
          e_tx = exp_tx_q.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(e_tx));
        end
      end
      if (bus.frame_error) fe_cnt++;
      if (bus.rx_overrun)  ov_cnt++;
      prev_rxv = bus.rx_valid;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ms0, fe0, ov0, t0, err_at, bad, n;
    vec = 0; miss = 0; ms_cnt = 0; tx_seen = 0; fe_cnt = 0; ov_cnt = 0;
    mult_lat       = 3;
    bp_hold        = 1'b0;
    uart_reset     = 1'b1;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    repeat (3) @(posedge clk_int);
    #1 uart_reset = 1'b0;
    @(negedge clk_int);
    check_all_zero("reset");

    // basic frame
    ms0 = ms_cnt;
    queue_frame(32'h1234_0056, 32'h0006_1D78);
    send4(8'h12, 8'h34, 8'h00, 8'h56);
    finish_frame("basic", ms0);

    // inter-byte timeout after a partial frame
    ms0 = ms_cnt;
    fe0 = fe_cnt;
    send_byte(8'hAA);
    send_byte(8'hBB);
    err_at = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk_int);
      if (bus.frame_error && err_at == 0) err_at = i;
    end
    check("to_err_cycle", err_at, 32'd100);
    check("to_err_count", fe_cnt - fe0, 32'd1);
    check("to_no_mstart", ms_cnt - ms0, 32'd0);
    check("to_busy", 32'(bus.busy), 32'd0);
    ms0 = ms_cnt;
    queue_frame(32'h0002_0003, 32'h0000_0006);
    send4(8'h00, 8'h02, 8'h00, 8'h03);
    finish_frame("to_follow", ms0);

    // byte arriving while the multiplier is busy
    mult_lat = 10;
    ms0 = ms_cnt;
    ov0 = ov_cnt;
    queue_frame(32'h0003_0004, 32'h0000_000C);
    send4(8'h00, 8'h03, 8'h00, 8'h04);
    send_byte(8'hFF);
    finish_frame("ovr", ms0);
    check("ovr_pulse", ov_cnt - ov0, 32'd1);
    mult_lat = 3;

    // transmitter backpressure on entry to the send phase
    ms0 = ms_cnt;
    bp_hold = 1'b1;
    queue_frame(32'h0009_0009, 32'h0000_0051);
    send4(8'h00, 8'h09, 8'h00, 8'h09);
    n = 0;
    while (!bus.mult_done && n < 200) begin
      @(negedge clk_int);
      n++;
    end
    check("bp_done_seen", 32'(bus.mult_done), 32'd1);
    bad = 0;
    repeat (50) begin
      @(negedge clk_int);
      if (bus.tx_start) bad++;
    end
    check("bp_no_start", bad, 32'd0);
    @(posedge clk_int);
    #1 bp_hold = 1'b0;
    @(negedge clk_int);
    check("bp_start", 32'(bus.tx_start), 32'd1);
    check("bp_data", 32'(bus.tx_data), 32'd0);
    finish_frame("bp", ms0);

    // reset in the middle of returning a product
    t0 = tx_seen;
    queue_frame(32'h0011_0022, 32'h0000_0242);
    send4(8'h00, 8'h11, 8'h00, 8'h22);
    n = 0;
    while (tx_seen < t0 + 2 && n < 2000) begin
      @(posedge clk_int);
      n++;
    end
    check("rst_two_bytes", 32'(tx_seen - t0), 32'd2);
    #1 uart_reset = 1'b1;
    @(posedge clk_int);
    #1 uart_reset = 1'b0;
    exp_tx_q.delete();
    @(negedge clk_int);
    check_all_zero("midrst");
    ms0 = ms_cnt;
    queue_frame(32'h0001_0001, 32'h0000_0001);
    send4(8'h00, 8'h01, 8'h00, 8'h01);
    finish_frame("post_rst", ms0);

    // byte arriving on the exact timeout cycle is accepted
    ms0 = ms_cnt;
    fe0 = fe_cnt;
    queue_frame(32'h0007_0005, 32'h0000_0023);
    send_byte(8'h00);
    send_byte(8'h07);
    repeat (98) @(posedge clk_int);
    send_byte(8'h00);
    send_byte(8'h05);
    finish_frame("bnd", ms0);
    check("bnd_no_err", fe_cnt - fe0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/uart_mult_link.md
Name: uart_mult_link

Overview:
Byte-stream protocol engine that connects the UART byte-level RX/TX pair to the multiplier core. It consumes received bytes and assembles them into two operands. It launches one multiplication, waits for the result, and streams the product back to the host through the UART transmitter. This is the multiplier-side end of the host link.

Parameters:
OPERAND_BYTES, 2, bytes per operand; operand width W = 8*OPERAND_BYTES; result width 2W, sent as 2*OPERAND_BYTES bytes.
TIMEOUT_CYCLES, 24'd1000000, inter-byte idle limit in clk_int cycles while a frame is partially received.

Ports:
clk_int  in  1  system clock
uart_reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte, valid when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
tx_ready  in  1  transmitter idle and able to accept a byte
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit request
mult_a  out  W  operand A
mult_b  out  W  operand B
mult_start  out  1  one-cycle multiply launch
mult_done  in  1  one-cycle strobe, mult_result valid
mult_result  in  2W  product
busy  out  1  high in every state except RX with byte count 0
frame_error  out  1  one-cycle pulse on inter-byte timeout
rx_overrun  out  1  one-cycle pulse when a byte arrives outside RX

Behaviour:
- Reset values (one clk_int edge with uart_reset=1, highest priority, any state):
  - Outputs: tx_data=0, tx_start=0, mult_a=0, mult_b=0, mult_start=0, busy=0, frame_error=0, rx_overrun=0.
  - Internal: FSM=RX, byte count=0, timeout counter=0, result register=0.
- Frame format: 2*OPERAND_BYTES bytes, all MSB first. First the A bytes, then the B bytes.
- RX state, on rx_valid:
  - Shift rx_data into the A shift register while count < OPERAND_BYTES, otherwise into B.
  - Increment count and clear the timeout counter.
- RX state, last byte:
  - Move to START on the cycle the final byte's rx_valid is sampled.
  - mult_a/mult_b hold the full operands from the next cycle on.
- mult_a/mult_b are driven directly from the shift registers. They are stable from START until the next frame's first byte.
- START: assert mult_start for exactly one cycle, the cycle after the last rx_valid. Then go to WAIT_MULT.
- WAIT_MULT: on mult_done, capture mult_result into the result register, set byte index=0, go to TX_SEND. There is no timeout here.
- TX_SEND:
  - When tx_ready=1, drive tx_data = result byte [index], MSB byte first, and pulse tx_start for one cycle. Go to TX_WAIT_LO.
  - While tx_ready=0, wait with tx_start=0.
- TX_WAIT_LO: wait for tx_ready=0, which acknowledges transmitter take-up, then go to TX_WAIT_HI.
- TX_WAIT_HI: wait for tx_ready=1. Then:
  - if index = 2*OPERAND_BYTES-1: clear count and go to RX;
  - otherwise increment index and go to TX_SEND.
- tx_data holds its value until the next tx_start.
- Timeout:
  - In RX with 0 < count, the timeout counter increments each cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, on that cycle: pulse frame_error, clear count and counter, discard partial operands, stay in RX.
  - If rx_valid arrives on that same cycle, the byte wins: it is accepted and there is no error.
- rx_valid in any state other than RX: byte is dropped and rx_overrun pulses one cycle. FSM and data are unaffected.
- mult_done outside WAIT_MULT: ignored.
- No wrap hazards: count, index and timeout counters saturate at their terminal values by construction.

Test Plan:
- Basic frame (OPERAND_BYTES=2):
  - Stimulus: rx bytes 0x12,0x34,0x00,0x56; model returns mult_result=0x00061D78 three cycles after mult_start.
  - Required: mult_a=0x1234, mult_b=0x0056; mult_start pulses once, exactly one cycle after the 4th rx_valid.
  - Required: tx bytes in order 0x00,0x06,0x1D,0x78, four tx_start pulses; busy falls after the 4th byte completes.
- Timeout (TIMEOUT_CYCLES=100):
  - Stimulus: send 0xAA,0xBB, then idle 100 cycles.
  - Required: frame_error pulses once, no mult_start.
  - Follow-up: bytes 0x00,0x02,0x00,0x03 with product 0x6 -> mult_a=0x0002, mult_b=0x0003; tx 0x00,0x00,0x00,0x06.
- Overrun:
  - Stimulus: rx_valid with 0xFF during WAIT_MULT.
  - Required: rx_overrun pulses one cycle; the result and next frame are unaffected.
- Transmitter backpressure:
  - Stimulus: hold tx_ready=0 for 50 cycles entering TX_SEND.
  - Required: tx_start stays 0 throughout; it asserts on the first cycle tx_ready=1 with tx_data=0x00.
- Reset mid-transmit:
  - Stimulus: assert uart_reset after the 2nd result byte.
  - Required: next cycle all outputs are 0 and busy=0; a fresh frame 0x00,0x01,0x00,0x01 yields mult_start and tx 0x00,0x00,0x00,0x01.
- Boundary: rx_valid on the exact timeout cycle -> byte accepted, no frame_error.
